// File: rtl/led_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// led_gpio_ctrl
//   Memory-mapped LED / GPIO output controller for the CPU peripheral bus.
//   It holds the LED pattern, the counter channel select and the auxiliary
//   GPIO bits. It also provides atomic set/clear of LEDs and a per-LED blink
//   mask that is gated by a free-running half-period timer.
//
//   Register map (word select on addr):
//     0 DATA  : write {aux, led, counter_set}; read back the same layout
//     1 SET   : led |= wdata[LED_W-1:0];  read the gated LED view (led_out)
//     2 CLR   : led &= ~wdata[LED_W-1:0]; read the raw LED register
//     3 BLINK : write the blink mask and resync the timer;
//               read {phase, zeros, mask}
//
// Ports
//   clk          in   1          system clock, all state on rising edge
//   rst          in   1          synchronous active-high reset
//   we           in   1          write strobe, one write per asserted cycle
//   addr         in   2          register select
//   wdata        in   32         write data
//   rdata        out  32         combinational readback of register at addr
//   led_out      out  LED_W      LED drive after blink gating
//   counter_set  out  2          counter channel select
//   gpio_aux     out  30-LED_W   auxiliary GPIO outputs
// ---------------------------------------------------------------------------
module led_gpio_ctrl #(
  parameter int               LED_W       = 8,
  parameter logic [LED_W-1:0] RST_PATTERN = 8'hAA,
  parameter int               BLINK_DIV   = 25000000,
  parameter int               PRESC_W     = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [LED_W-1:0]    led_out,
  output logic [1:0]          counter_set,
  output logic [29-LED_W:0]   gpio_aux
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_BLINK = 2'd3;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

  logic [LED_W-1:0]   led_q,   led_d;
  logic [1:0]         cs_q,    cs_d;
  logic [29-LED_W:0]  aux_q,   aux_d;
  logic [LED_W-1:0]   mask_q,  mask_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               phase_q, phase_d;

  logic               presc_wrap;

  assign presc_wrap = (presc_q == PRESC_LAST);

  // Register write path and blink timer next-state.
  always_comb begin
    led_d   = led_q;
    cs_d    = cs_q;
    aux_d   = aux_q;
    mask_d  = mask_q;
    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    phase_d = phase_q ^ presc_wrap;

    if (we) begin
      case (addr)
        ADDR_DATA: begin
          cs_d  = wdata[1:0];
          led_d = wdata[LED_W+1:2];
          aux_d = wdata[31:LED_W+2];
        end
        ADDR_SET: led_d = led_q | wdata[LED_W-1:0];
        ADDR_CLR: led_d = led_q & ~wdata[LED_W-1:0];
        default: begin
          // A new mask restarts the blink on a clean "on" half-period,
          // overriding a wrap toggle that lands in the same cycle.
          mask_d  = wdata[LED_W-1:0];
          presc_d = '0;
          phase_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= RST_PATTERN;
      cs_q    <= 2'd0;
      aux_q   <= '0;
      mask_q  <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      cs_q    <= cs_d;
      aux_q   <= aux_d;
      mask_q  <= mask_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  // Masked LEDs are blanked during the odd half-period; others follow led_q.
  generate
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_gate
      assign led_out[gi] = led_q[gi] & ~(mask_q[gi] & phase_q);
    end
  endgenerate

  assign counter_set = cs_q;
  assign gpio_aux    = aux_q;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_DATA:  rdata = {aux_q, led_q, cs_q};
      ADDR_SET:   rdata = {{(32-LED_W){1'b0}}, led_out};
      ADDR_CLR:   rdata = {{(32-LED_W){1'b0}}, led_q};
      default:    rdata = {phase_q, {(31-LED_W){1'b0}}, mask_q};
    endcase
  end

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_gpio_ctrl
//   Directed bench for led_gpio_ctrl with LED_W=8, BLINK_DIV=4.
//   Inputs are driven on the falling edge and outputs sampled there too,
//   half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_led_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led_out;
  logic [1:0]  counter_set;
  logic [21:0] gpio_aux;

  int checks = 0;
  int errors = 0;

  led_gpio_ctrl #(
    .LED_W      (8),
    .RST_PATTERN(8'hAA),
    .BLINK_DIV  (4),
    .PRESC_W    (25)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .led_out    (led_out),
    .counter_set(counter_set),
    .gpio_aux   (gpio_aux)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  // Combinational readback, no clock edge involved.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_rd;
  logic [7:0]  exp_led;
  logic        exp_phase;

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- 1. reset values ----
    chk("reset led_out", {24'd0, led_out}, 32'h0000_00AA);
    chk("reset counter_set", {30'd0, counter_set}, 32'd0);
    chk("reset gpio_aux", {10'd0, gpio_aux}, 32'd0);
    bus_read(2'd0, rd);
    chk("reset rdata0", rd, 32'h0000_02A8);
    bus_read(2'd3, rd);
    chk("reset rdata3", rd, 32'h0000_0000);

    // Mid-blink reset: mask all, run 5 cycles so phase=1, presc=1.
    bus_write(2'd3, 32'h0000_00FF);
    repeat (5) @(negedge clk);
    bus_read(2'd3, rd);
    chk("midblink rdata3", rd, 32'h8000_00FF);
    chk("midblink led_out", {24'd0, led_out}, 32'h0000_0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulse");
    chk("rst midblink led_out", {24'd0, led_out}, 32'h0000_00AA);
    bus_read(2'd3, rd);
    chk("rst midblink rdata3", rd, 32'h0000_0000);
    // presc restarted at 0: phase stays 0 through presc=3, toggles after.
    repeat (3) @(negedge clk);
    bus_read(2'd3, rd);
    chk("rst presc phase k3", rd, 32'h0000_0000);
    @(negedge clk);
    bus_read(2'd3, rd);
    chk("rst presc phase k4", rd, 32'h8000_0000);

    // ---- 2. DATA write ----
    bus_write(2'd0, 32'hFFFF_FC07);
    chk("data led_out", {24'd0, led_out}, 32'h0000_0001);
    chk("data counter_set", {30'd0, counter_set}, 32'd3);
    chk("data gpio_aux", {10'd0, gpio_aux}, 32'h003F_FFFF);
    bus_read(2'd0, rd);
    chk("data rdata0", rd, 32'hFFFF_FC07);

    // ---- 3. SET then CLR back to back from led=0x0F ----
    bus_write(2'd0, 32'h0000_003C);
    bus_read(2'd2, rd);
    chk("led 0F rdata2", rd, 32'h0000_000F);
    we = 1'b1; addr = 2'd1; wdata = 32'hFFFF_FFF0;   // upper bits must be ignored
    @(posedge clk);
    @(negedge clk);
    $display("write addr=1 data=0x%08h", wdata);
    addr = 2'd2; wdata = 32'h0000_003C;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    $display("write addr=2 data=0x%08h", wdata);
    bus_read(2'd2, rd);
    chk("setclr rdata2", rd, 32'h0000_00C3);
    chk("setclr led_out", {24'd0, led_out}, 32'h0000_00C3);
    bus_read(2'd0, rd);
    chk("setclr rdata0", rd, 32'h0000_030C);

    // ---- 4. blink 0x0F over led=0xFF ----
    bus_write(2'd0, 32'h0000_03FC);
    bus_write(2'd3, 32'h0000_000F);
    for (int k = 0; k < 12; k++) begin
      exp_phase = ((k / 4) % 2) == 1;
      exp_led   = exp_phase ? 8'hF0 : 8'hFF;
      chk($sformatf("blink led_out k%0d", k), {24'd0, led_out}, {24'd0, exp_led});
      bus_read(2'd3, rd);
      chk($sformatf("blink rdata3 k%0d", k), rd, {exp_phase, 23'd0, 8'h0F});
      @(negedge clk);
    end

    // ---- 5. BLINK write landing on the wrap cycle ----
    bus_write(2'd3, 32'h0000_000F);
    repeat (3) @(negedge clk);          // presc=3: next edge is the wrap
    bus_write(2'd3, 32'h0000_000F);
    for (int k = 0; k < 5; k++) begin
      exp_phase = (k == 4);
      bus_read(2'd3, rd);
      chk($sformatf("wrap resync rdata3 k%0d", k), rd, {exp_phase, 23'd0, 8'h0F});
      @(negedge clk);
    end

    // rst and we together: reset wins.
    rst = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    $display("reset with write addr=0 data=0xffffffff");
    bus_read(2'd0, rd);
    chk("rst+we rdata0", rd, 32'h0000_02A8);
    chk("rst+we led_out", {24'd0, led_out}, 32'h0000_00AA);
    bus_read(2'd3, rd);
    chk("rst+we rdata3", rd, 32'h0000_0000);

    // ---- 6. idle bus with random addr/wdata ----
    bus_write(2'd0, 32'hDEAD_BEEF);     // led=0xBB, cs=3
    bus_write(2'd3, 32'h0000_005A);     // timer resync, k=0 here
    for (int k = 0; k < 100; k++) begin
      we        = 1'b0;
      wdata     = $urandom;
      addr      = 2'($urandom_range(0, 3));
      exp_phase = ((k / 4) % 2) == 1;
      exp_led   = exp_phase ? 8'hA1 : 8'hBB;
      case (addr)
        2'd0:    exp_rd = 32'hDEAD_BEEF;
        2'd1:    exp_rd = {24'd0, exp_led};
        2'd2:    exp_rd = 32'h0000_00BB;
        default: exp_rd = {exp_phase, 23'd0, 8'h5A};
      endcase
      #1;
      $display("idle k=%0d addr=%0d wdata=0x%08h rdata=0x%08h", k, addr, wdata, rdata);
      chk($sformatf("idle led_out k%0d", k), {24'd0, led_out}, {24'd0, exp_led});
      chk($sformatf("idle rdata k%0d", k), rdata, exp_rd);
      @(negedge clk);
    end
    chk("idle counter_set", {30'd0, counter_set}, 32'd3);
    chk("idle gpio_aux", {10'd0, gpio_aux}, 32'h0037_AB6F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
